// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU encodings,
// sequencer states and a small opcode-to-ALU mapping helper.
package proc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_NAN = 3'b010;
    localparam logic [2:0] OP_OUT = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_REP = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        HALT = 3'd4
    } state_t;

    // Maps an arithmetic opcode onto the ALU operation code.
    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] code;
        code = ALU_ADD;
        case (op)
            OP_SUB:  code = ALU_SUB;
            OP_NAN:  code = ALU_NAND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary address to one-hot decoder with enable. Addresses at or beyond N
// decode to all-zero, so non-power-of-two register files stay safe.
module onehot_decoder #(
    parameter int N  = 8,
    parameter int AW = $clog2(N)
) (
    input  logic [AW-1:0] addr,
    input  logic          en,
    output logic [N-1:0]  onehot
);

    // Compare the address against every legal index; no match leaves zero.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (en && (addr == AW'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/proc_control_fsm.sv
// Self-timed instruction sequencer for the multi-cycle datapath. Latches an
// instruction on run, walks T1..T3 and decodes all datapath controls from the
// state register and the latched instruction only.
// Optional macro CU_ILLEGAL_TRAP_EN: illegal opcodes trap into a HALT state
// (busy held, illegal sticky, no done) that only reset leaves. Without it an
// illegal opcode is a one-step NOP that still retires and is counted.
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int REG_COUNT = 8,
    parameter int RA_W      = $clog2(REG_COUNT),
    parameter int CNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  run,
    input  logic [3+2*RA_W-1:0]   instr,
    output logic                  busy,
    output logic                  done,
    output logic [REG_COUNT-1:0]  reg_sel,
    output logic                  imm_sel,
    output logic                  g_sel,
    output logic [REG_COUNT-1:0]  reg_en,
    output logic                  a_en,
    output logic                  g_en,
    output logic [1:0]            alu_op,
    output logic                  out_en,
    output logic                  illegal,
    output logic [CNT_W-1:0]      instr_count
);

    localparam int IW = 3 + 2 * RA_W;

    state_t               state;
    state_t               state_next;
    logic [IW-1:0]        ir;
    logic [2:0]           op;
    logic [RA_W-1:0]      rx;
    logic [RA_W-1:0]      ry;
    logic                 dec_en;
    logic [REG_COUNT-1:0] rx_oh;
    logic [REG_COUNT-1:0] ry_oh;

    assign op     = ir[IW-1 -: 3];
    assign rx     = ir[2*RA_W-1 -: RA_W];
    assign ry     = ir[RA_W-1:0];
    assign dec_en = (state == T1) || (state == T2) || (state == T3);

    onehot_decoder #(.N(REG_COUNT), .AW(RA_W)) u_rx_dec (
        .addr   (rx),
        .en     (dec_en),
        .onehot (rx_oh)
    );

    onehot_decoder #(.N(REG_COUNT), .AW(RA_W)) u_ry_dec (
        .addr   (ry),
        .en     (dec_en),
        .onehot (ry_oh)
    );

    // State register plus instruction latch; IR only loads when a run is accepted.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
            ir    <= '0;
        end else begin
            state <= state_next;
            if ((state == IDLE) && run) begin
                ir <= instr;
            end
        end
    end

    // Retired-instruction counter, advances on every done and wraps naturally.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            instr_count <= '0;
        end else if (done) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    // Next-state and datapath control decode from state and IR.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        reg_sel    = '0;
        imm_sel    = 1'b0;
        g_sel      = 1'b0;
        reg_en     = '0;
        a_en       = 1'b0;
        g_en       = 1'b0;
        alu_op     = ALU_ADD;
        out_en     = 1'b0;
        illegal    = 1'b0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_next = T1;
                end
            end
            T1: begin
                busy = 1'b1;
                case (op)
                    OP_ADD, OP_SUB, OP_NAN: begin
                        reg_sel    = rx_oh;
                        a_en       = 1'b1;
                        state_next = T2;
                    end
                    OP_REP: begin
                        reg_sel    = ry_oh;
                        reg_en     = rx_oh;
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                    OP_LDI: begin
                        imm_sel    = 1'b1;
                        reg_en     = rx_oh;
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                    OP_OUT: begin
                        reg_sel    = rx_oh;
                        out_en     = 1'b1;
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                    default: begin
                        illegal = 1'b1;
`ifdef CU_ILLEGAL_TRAP_EN
                        state_next = HALT;
`else
                        done       = 1'b1;
                        state_next = IDLE;
`endif
                    end
                endcase
            end
            T2: begin
                busy       = 1'b1;
                reg_sel    = ry_oh;
                g_en       = 1'b1;
                alu_op     = alu_code(op);
                state_next = T3;
            end
            T3: begin
                busy       = 1'b1;
                g_sel      = 1'b1;
                reg_en     = rx_oh;
                done       = 1'b1;
                state_next = IDLE;
            end
            HALT: begin
`ifdef CU_ILLEGAL_TRAP_EN
                busy       = 1'b1;
                illegal    = 1'b1;
                state_next = HALT;
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: a behavioural model pushes the
// expected per-cycle control vector for each instruction and every cycle pops
// and compares one. A second small instance (6 registers, 4-bit counter)
// covers out-of-range operands and counter wrap.
module tb_proc_control_fsm;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic [7:0]  reg_sel;
        logic        imm_sel;
        logic        g_sel;
        logic [7:0]  reg_en;
        logic        a_en;
        logic        g_en;
        logic [1:0]  alu_op;
        logic        out_en;
        logic        illegal;
        logic [15:0] cnt;
    } obs_t;

    logic        clk;
    logic        resetn;
    logic        run;
    logic [8:0]  instr;
    logic        busy, done, imm_sel, g_sel, a_en, g_en, out_en, illegal;
    logic [7:0]  reg_sel, reg_en;
    logic [1:0]  alu_op;
    logic [15:0] instr_count;

    logic        run2;
    logic [8:0]  instr2;
    logic        busy2, done2, imm_sel2, g_sel2, a_en2, g_en2, out_en2, illegal2;
    logic [5:0]  reg_sel2, reg_en2;
    logic [1:0]  alu_op2;
    logic [3:0]  instr_count2;

    obs_t        obsNow;
    obs_t        expQ[$];
    logic [15:0] expCount;
    logic [3:0]  expCount2;
    int          checks;
    int          errors;

    proc_control_fsm #(.REG_COUNT(8), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .run(run), .instr(instr),
        .busy(busy), .done(done), .reg_sel(reg_sel), .imm_sel(imm_sel),
        .g_sel(g_sel), .reg_en(reg_en), .a_en(a_en), .g_en(g_en),
        .alu_op(alu_op), .out_en(out_en), .illegal(illegal),
        .instr_count(instr_count)
    );

    proc_control_fsm #(.REG_COUNT(6), .CNT_W(4)) dut2 (
        .clk(clk), .resetn(resetn), .run(run2), .instr(instr2),
        .busy(busy2), .done(done2), .reg_sel(reg_sel2), .imm_sel(imm_sel2),
        .g_sel(g_sel2), .reg_en(reg_en2), .a_en(a_en2), .g_en(g_en2),
        .alu_op(alu_op2), .out_en(out_en2), .illegal(illegal2),
        .instr_count(instr_count2)
    );

    assign obsNow = {busy, done, reg_sel, imm_sel, g_sel, reg_en,
                     a_en, g_en, alu_op, out_en, illegal, instr_count};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired before the sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    function automatic obs_t blankVec(input logic [15:0] c);
        obs_t e;
        e = '0;
        e.cnt = c;
        return e;
    endfunction

    function automatic logic [7:0] oh8(input logic [2:0] a);
        logic [7:0] v;
        v = 8'h01 << a;
        return v;
    endfunction

    // Pushes expected vectors: nSteps busy cycles, then nTrail trailing cycles.
    task automatic modelInstr(input logic [8:0] w, output int nSteps, output int nTrail);
        logic [2:0] op, rx, ry;
        obs_t e;
        op = w[8:6];
        rx = w[5:3];
        ry = w[2:0];
        nTrail = 1;
        case (op)
            3'b000, 3'b001, 3'b010: begin
                e = blankVec(expCount); e.busy = 1; e.reg_sel = oh8(rx); e.a_en = 1;
                expQ.push_back(e);
                e = blankVec(expCount); e.busy = 1; e.reg_sel = oh8(ry); e.g_en = 1;
                e.alu_op = (op == 3'b000) ? 2'b00 : (op == 3'b001) ? 2'b01 : 2'b10;
                expQ.push_back(e);
                e = blankVec(expCount); e.busy = 1; e.g_sel = 1; e.reg_en = oh8(rx); e.done = 1;
                expQ.push_back(e);
                nSteps = 3;
            end
            3'b111: begin
                e = blankVec(expCount); e.busy = 1; e.done = 1;
                e.reg_sel = oh8(ry); e.reg_en = oh8(rx);
                expQ.push_back(e);
                nSteps = 1;
            end
            3'b101: begin
                e = blankVec(expCount); e.busy = 1; e.done = 1;
                e.imm_sel = 1; e.reg_en = oh8(rx);
                expQ.push_back(e);
                nSteps = 1;
            end
            3'b100: begin
                e = blankVec(expCount); e.busy = 1; e.done = 1;
                e.reg_sel = oh8(rx); e.out_en = 1;
                expQ.push_back(e);
                nSteps = 1;
            end
            default: begin
                e = blankVec(expCount); e.busy = 1; e.illegal = 1;
`ifndef CU_ILLEGAL_TRAP_EN
                e.done = 1;
`endif
                expQ.push_back(e);
                nSteps = 1;
            end
        endcase
`ifdef CU_ILLEGAL_TRAP_EN
        if (op == 3'b011 || op == 3'b110) begin
            e = blankVec(expCount); e.busy = 1; e.illegal = 1;
            for (int k = 0; k < 3; k++) expQ.push_back(e);
            nTrail = 3;
        end else begin
            expCount = expCount + 16'd1;
            expQ.push_back(blankVec(expCount));
        end
`else
        expCount = expCount + 16'd1;
        expQ.push_back(blankVec(expCount));
`endif
    endtask

    // Pops one expected vector and compares it against the sampled outputs.
    task automatic checkOutput(input string tag);
        obs_t e;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s scoreboard empty, observed=%h", tag, obsNow);
        end else begin
            e = expQ.pop_front();
            assert (obsNow === e) else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, obsNow, e);
            end
        end
    endtask

    // Generic comparison used for the second instance.
    task automatic check2(input string tag, input logic [15:0] o, input logic [15:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, o, x);
        end
    endtask

    // Issues one instruction; with hold, run stays high and instr is scrambled while busy.
    task automatic applyStimulus(input string tag, input logic [8:0] w, input bit hold);
        int nSteps, nTrail;
        modelInstr(w, nSteps, nTrail);
        run   = 1'b1;
        instr = w;
        for (int k = 0; k < nSteps + nTrail; k++) begin
            @(posedge clk);
            #1;
            checkOutput(tag);
            if (!hold || k == nSteps - 1) run = 1'b0;
            if (hold && k == 0) instr = ~w;
        end
    endtask

    // Single REP on the 6-register instance, checking the T1 controls and count.
    task automatic rep2(input logic [8:0] w);
        logic [5:0] xs, xe;
        xs = (w[2:0] < 3'd6) ? (6'h01 << w[2:0]) : 6'h00;
        xe = (w[5:3] < 3'd6) ? (6'h01 << w[5:3]) : 6'h00;
        run2   = 1'b1;
        instr2 = w;
        @(posedge clk);
        #1;
        run2 = 1'b0;
        check2("rep2_done", {15'd0, done2}, 16'd1);
        check2("rep2_sel_en", {4'd0, reg_sel2, reg_en2}, {4'd0, xs, xe});
        @(posedge clk);
        #1;
        expCount2 = expCount2 + 4'd1;
        check2("rep2_count", {12'd0, instr_count2}, {12'd0, expCount2});
    endtask

    initial begin
        obs_t e;
        checks    = 0;
        errors    = 0;
        expCount  = 16'd0;
        expCount2 = 4'd0;
        resetn    = 1'b1;
        run       = 1'b0;
        instr     = 9'h000;
        run2      = 1'b0;
        instr2    = 9'h000;

        repeat (2) @(posedge clk);
        #1;
        expQ.push_back(blankVec(16'd0));
        checkOutput("reset_state");
        resetn = 1'b0;
        @(posedge clk);
        #1;
        expQ.push_back(blankVec(16'd0));
        checkOutput("idle_after_reset");

        applyStimulus("add_r2_r5", 9'h015, 1'b0);
        applyStimulus("sub_r7_r0_hold", 9'h078, 1'b1);
        applyStimulus("ldi_r3", 9'h158, 1'b0);
        applyStimulus("out_r3", 9'h118, 1'b0);
        applyStimulus("nan_r1_r6", 9'h08E, 1'b0);
        applyStimulus("rep_r4_r1", 9'h1E1, 1'b0);

        // Reset asserted during T2 of an ADD.
        run   = 1'b1;
        instr = 9'h015;
        e = blankVec(expCount); e.busy = 1; e.reg_sel = 8'h04; e.a_en = 1;
        expQ.push_back(e);
        e = blankVec(expCount); e.busy = 1; e.reg_sel = 8'h20; e.g_en = 1;
        expQ.push_back(e);
        @(posedge clk); #1; run = 1'b0; checkOutput("midadd_t1");
        @(posedge clk); #1; checkOutput("midadd_t2");
        resetn = 1'b1;
        #1;
        expCount = 16'd0;
        expQ.push_back(blankVec(16'd0));
        checkOutput("midadd_reset");
        #1;
        resetn = 1'b0;
        @(posedge clk); #1;
        expQ.push_back(blankVec(16'd0));
        checkOutput("midadd_idle");
        applyStimulus("add_after_reset", 9'h015, 1'b0);

        rep2(9'h1D6);
        rep2(9'h1F8);
        for (int k = 0; k < 15; k++) rep2(9'h1C8);
        check2("wrap_count", {12'd0, instr_count2}, 16'd1);

`ifdef CU_ILLEGAL_TRAP_EN
        applyStimulus("illegal_011_trap", 9'h0C0, 1'b0);
        resetn = 1'b1;
        #1;
        expCount = 16'd0;
        expQ.push_back(blankVec(16'd0));
        checkOutput("halt_reset");
        #1;
        resetn = 1'b0;
        applyStimulus("rep_after_halt", 9'h1E1, 1'b0);
`else
        applyStimulus("illegal_110_nop", 9'h180, 1'b0);
        applyStimulus("illegal_011_nop", 9'h0C0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/proc_control_fsm.md
# proc_control_fsm

Parametrised instruction sequencer for the simple multi-cycle datapath: latches one instruction on a `run` request and steps through its T1..T3 micro-steps with an internal step counter. It drives one-hot register select/enable, accumulator/result enables, the ALU op and the immediate/result bus muxes. It sits between the instruction source and the register file/ALU and replaces externally supplied step counts with a self-timed `run`/`done` handshake.

## Interface
- `REG_COUNT`, 8: number of general registers; must be ≥ 2.
- `RA_W`, `$clog2(REG_COUNT)`: register address width.
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk` input 1: rising-edge clock.
- `resetn` input 1: reset, asynchronous, active-high.
- `run` input 1: start request, sampled only in IDLE.
- `instr` input `3+2*RA_W`: instruction word {op[2:0], rx, ry}.
- `busy` output 1: an instruction is in progress (T1..T3).
- `done` output 1: one-cycle pulse in an instruction's final step.
- `reg_sel` output `REG_COUNT`: one-hot register drive onto the bus.
- `imm_sel` output 1: immediate drives the bus.
- `g_sel` output 1: result register G drives the bus.
- `reg_en` output `REG_COUNT`: one-hot register write enable.
- `a_en` output 1: accumulator A load.
- `g_en` output 1: result register G load.
- `alu_op` output 2: 00 add, 01 sub, 10 nand.
- `out_en` output 1: output port load.
- `illegal` output 1: illegal opcode indication (see Configuration).
- `instr_count` output `CNT_W`: retired-instruction count.

## Operation
- Opcodes:
  - 000 ADD rx←rx+ry
  - 001 SUB rx←rx−ry
  - 010 NAN rx←~(rx&ry)
  - 100 OUT port←rx
  - 101 LDI rx←imm
  - 111 REP rx←ry
  - 011 and 110 are illegal.
- States: IDLE, T1, T2, T3.
  - IDLE with `run`=1: IR←`instr`, next state T1.
  - IDLE with `run`=0: stay in IDLE.
- ALU ops (ADD/SUB/NAN):
  - T1: `reg_sel`=onehot(rx), `a_en`.
  - T2: `reg_sel`=onehot(ry), `g_en`, `alu_op` per opcode.
  - T3: `g_sel`, `reg_en`=onehot(rx), `done`, then IDLE.
- REP: T1 `reg_sel`=onehot(ry), `reg_en`=onehot(rx), `done`, then IDLE.
- LDI: T1 `imm_sel`, `reg_en`=onehot(rx), `done`, then IDLE.
- OUT: T1 `reg_sel`=onehot(rx), `out_en`, `done`, then IDLE.
- Illegal opcode: T1 asserts `done` with no enables, then IDLE (see Configuration).
- rx/ry ≥ REG_COUNT (only possible when REG_COUNT is not a power of 2): the selects/enables for that operand are all-zero; sequencing is unchanged.
- All outputs are decoded combinationally from the state register and IR only. No output depends on `instr` or `run` directly.
- `instr_count` increments on every `done` cycle, wraps modulo 2^CNT_W, and counts illegal instructions.
- At most one bit of `reg_sel`/`imm_sel`/`g_sel` is high in any cycle.

## Timing
- Reset values: state IDLE, IR 0, `instr_count` 0, `illegal` 0; all outputs 0.
- Latency from `run` sampled to `done`:
  - ALU ops: 3 cycles.
  - REP/LDI/OUT/illegal: 1 cycle.
- `busy`=1 exactly in T1..T3.
- `done` and IDLE coincide never: `run` can be accepted on the cycle after `done`. Back-to-back throughput is 2 cycles for a 1-step instruction and 4 cycles for an ALU op.
- `run` while busy is ignored and not queued.
- `instr` changes while busy have no effect, because IR holds the latched word.
- `resetn` asserted mid-instruction: immediate return to IDLE, every enable drops in the same cycle, no partial write completes, and `instr_count` clears.

## Configuration
- `CU_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode sets `illegal` sticky, and the FSM enters a HALT state with `busy`=1 and no `done`.
  - HALT is left only by reset; `instr_count` does not increment.
- Not defined:
  - An illegal opcode is a 1-step NOP with `done` and a count increment.
  - `illegal` pulses high for that T1 cycle only.

## Structure
- Shared package `proc_pkg`:
  - opcode localparams (OP_ADD…OP_REP)
  - ALU op encodings
  - state enum {IDLE, T1, T2, T3, HALT}
- Sub-module `onehot_decoder` (parameter N; addr → N-bit one-hot with enable input), instantiated for rx and ry.

## Test plan
- Reset mid-ADD: assert `resetn` during T2 -> all outputs 0 that cycle, state IDLE, `instr_count`=0.
- REG_COUNT=8, ADD r2,r5 (`instr`=9'h015), `run` pulse -> T1 `reg_sel`=8'h04 `a_en`; T2 `reg_sel`=8'h20 `g_en` `alu_op`=00; T3 `g_sel` `reg_en`=8'h04 `done`; count=1.
- SUB r7,r0 (9'h078) -> T2 `alu_op`=01; T3 `reg_en`=8'h80; `run` held high while busy is ignored.
- LDI r3 (9'h158) then OUT r3 (9'h118) back-to-back -> `imm_sel`+`reg_en`=8'h08 with `done`; 1 cycle IDLE; `reg_sel`=8'h08+`out_en` with `done`; count=2.
- Opcode 011 (9'h0C0):
  - Macro defined: `illegal` sticky, `busy` stays 1, no `done`, count unchanged.
  - Macro not defined: 1-cycle `illegal`+`done`, count+1.
- CNT_W=4, 17 REP instructions -> `instr_count` wraps to 1.
